// File: rtl/diffeq_seq_ctrl.sv
// diffeq_seq_ctrl: sequencing controller for the iterative diff-eq datapath.
// Loads operands under one-hot strobes, steps through NUM_PHASES compute
// phases per iteration, re-checks the loop condition and hands the result off
// with valid/ack. Holds no data, only sequencing state.
// Optional per-phase watchdog: define DIFFEQ_CTRL_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE  (0) | waiting for start
// LOAD  (1) | strobing operands in from op_sel until load_done
// COMPUTE(2)| running phase phase_idx, waiting for phase_done
// CHECK (3) | one cycle: bump iter_cnt, evaluate loop condition / limit
// DONE  (4) | result valid, waiting for ack
// 5..7      | illegal, fall back to IDLE
module diffeq_seq_ctrl #(
  parameter int NUM_OPS     = 4,
  parameter int NUM_PHASES  = 3,
  parameter int ITER_W      = 16,
  parameter int TIMEOUT_CYC = 255,
  localparam int PHASE_W    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_OPS-1:0] op_sel,
  input  logic               load_done,
  input  logic               phase_done,
  input  logic               continue_while,
  input  logic [ITER_W-1:0]  max_iter,
  input  logic               ack,
  output logic [NUM_OPS-1:0] load_en,
  output logic               phase_start,
  output logic [PHASE_W-1:0] phase_idx,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic [2:0]         state,
  output logic               busy,
  output logic               valid,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_CHECK   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [NUM_OPS-1:0] load_en_q, load_en_n;
  logic               phase_start_q, phase_start_n;
  logic [PHASE_W-1:0] phase_idx_q, phase_idx_n;
  logic [ITER_W-1:0]  iter_q, iter_n;
  logic               err_q, err_n;
  logic               last_phase;
  logic               iter_hits_max;

`ifdef DIFFEQ_CTRL_TIMEOUT_EN
  // Watchdog is a down-counter reloaded on phase entry; terminal count 0
  // marks the last budgeted cycle of the phase.
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_n;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  assign last_phase    = (phase_idx_q == PHASE_W'(NUM_PHASES - 1));
  // Widened compare so an all-ones iter_cnt never wraps into a false match.
  assign iter_hits_max = (max_iter != '0) &&
                         (({1'b0, iter_q} + (ITER_W+1)'(1)) == {1'b0, max_iter});

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      load_en_q     <= '0;
      phase_start_q <= 1'b0;
      phase_idx_q   <= '0;
      iter_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_n;
      load_en_q     <= load_en_n;
      phase_start_q <= phase_start_n;
      phase_idx_q   <= phase_idx_n;
      iter_q        <= iter_n;
      err_q         <= err_n;
    end
  end

`ifdef DIFFEQ_CTRL_TIMEOUT_EN
  // Per-phase watchdog register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_n;
  end
`endif

  // Next-state and next-output decode; abort overrides everything.
  always_comb begin
    state_n       = state_q;
    load_en_n     = '0;
    phase_start_n = 1'b0;
    phase_idx_n   = phase_idx_q;
    iter_n        = iter_q;
    err_n         = err_q;
`ifdef DIFFEQ_CTRL_TIMEOUT_EN
    wd_n          = wd_q;
`endif
    if (abort && (state_q != S_IDLE)) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_n = S_LOAD;
            iter_n  = '0;
            err_n   = 1'b0;
          end
        end
        S_LOAD: begin
          // Isolate the lowest set bit of op_sel.
          load_en_n = op_sel & (~op_sel + NUM_OPS'(1));
          if (load_done) begin
            state_n       = S_COMPUTE;
            phase_idx_n   = '0;
            phase_start_n = 1'b1;
`ifdef DIFFEQ_CTRL_TIMEOUT_EN
            wd_n          = WD_LOAD;
`endif
          end
        end
        S_COMPUTE: begin
          if (phase_done) begin
            if (last_phase) begin
              state_n = S_CHECK;
            end else begin
              phase_idx_n   = phase_idx_q + PHASE_W'(1);
              phase_start_n = 1'b1;
`ifdef DIFFEQ_CTRL_TIMEOUT_EN
              wd_n          = WD_LOAD;
`endif
            end
          end
`ifdef DIFFEQ_CTRL_TIMEOUT_EN
          else if (wd_q == '0) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            wd_n = wd_q - WD_W'(1);
          end
`endif
        end
        S_CHECK: begin
          if (iter_q != '1) iter_n = iter_q + ITER_W'(1);
          if (!continue_while) begin
            state_n = S_DONE;
            err_n   = 1'b0;
          end else if (iter_hits_max) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            state_n       = S_COMPUTE;
            phase_idx_n   = '0;
            phase_start_n = 1'b1;
`ifdef DIFFEQ_CTRL_TIMEOUT_EN
            wd_n          = WD_LOAD;
`endif
          end
        end
        S_DONE: begin
          if (ack) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign load_en     = load_en_q;
  assign phase_start = phase_start_q;
  assign phase_idx   = phase_idx_q;
  assign iter_cnt    = iter_q;
  assign state       = state_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_CHECK);
  assign valid       = (state_q == S_DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_diffeq_seq_ctrl.sv
// Testbench for diffeq_seq_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the sequencing rules.
module tb_diffeq_seq_ctrl;
  localparam int NUM_OPS     = 4;
  localparam int NUM_PHASES  = 3;
  localparam int ITER_W      = 16;
  localparam int TIMEOUT_CYC = 8;
  localparam int PHASE_W     = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               start, abort, load_done, phase_done, continue_while, ack;
  logic [NUM_OPS-1:0] op_sel;
  logic [ITER_W-1:0]  max_iter;
  logic [NUM_OPS-1:0] load_en;
  logic               phase_start;
  logic [PHASE_W-1:0] phase_idx;
  logic [ITER_W-1:0]  iter_cnt;
  logic [2:0]         state;
  logic               busy, valid, err;

  diffeq_seq_ctrl #(
    .NUM_OPS(NUM_OPS), .NUM_PHASES(NUM_PHASES), .ITER_W(ITER_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .op_sel(op_sel),
    .load_done(load_done), .phase_done(phase_done), .continue_while(continue_while),
    .max_iter(max_iter), .ack(ack), .load_en(load_en), .phase_start(phase_start),
    .phase_idx(phase_idx), .iter_cnt(iter_cnt), .state(state), .busy(busy),
    .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 load, 2 compute, 3 check, 4 done.
  int                 m_state, m_pidx, m_iter, m_phase_cycles;
  logic [NUM_OPS-1:0] m_load;
  bit                 m_pstart, m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pidx = 0; m_iter = 0; m_phase_cycles = 0;
    m_load = '0; m_pstart = 0; m_err = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    int ns, old_iter;
    logic [NUM_OPS-1:0] nl;
    bit nps;
    ns = m_state; nl = '0; nps = 0;
    if (abort && m_state != 0) begin
      ns = 0;
      m_err = 1;
    end else begin
      case (m_state)
        0: if (start) begin ns = 1; m_iter = 0; m_err = 0; end
        1: begin
          for (int i = 0; i < NUM_OPS; i++)
            if (op_sel[i]) begin nl[i] = 1'b1; break; end
          if (load_done) begin ns = 2; m_pidx = 0; nps = 1; m_phase_cycles = 0; end
        end
        2: begin
          if (phase_done) begin
            if (m_pidx == NUM_PHASES - 1) ns = 3;
            else begin m_pidx++; nps = 1; m_phase_cycles = 0; end
          end else begin
            m_phase_cycles++;
`ifdef DIFFEQ_CTRL_TIMEOUT_EN
            if (m_phase_cycles >= TIMEOUT_CYC) begin ns = 4; m_err = 1; end
`endif
          end
        end
        3: begin
          old_iter = m_iter;
          if (m_iter < (1 << ITER_W) - 1) m_iter++;
          if (!continue_while) begin ns = 4; m_err = 0; end
          else if (max_iter != 0 && old_iter + 1 == int'(max_iter)) begin ns = 4; m_err = 1; end
          else begin ns = 2; m_pidx = 0; nps = 1; m_phase_cycles = 0; end
        end
        4: if (ack) ns = 0;
        default: ns = 0;
      endcase
    end
    m_state = ns; m_load = nl; m_pstart = nps;
  endtask

  task automatic compare_all();
    chk("state", state, m_state);
    chk("load_en", load_en, m_load);
    chk("phase_start", phase_start, m_pstart);
    chk("phase_idx", phase_idx, m_pidx);
    chk("iter_cnt", iter_cnt, m_iter);
    chk("busy", busy, (m_state >= 1 && m_state <= 3));
    chk("valid", valid, (m_state == 4));
    chk("err", err, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; op_sel = '0; load_done = 0; phase_done = 0;
    continue_while = 0; max_iter = '0; ack = 0;
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    reset = 1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    reset = 0;

    // Operand load sequence, then first phase entry.
    start = 1; tick(); start = 0;
    chk("t1_state_load", state, 3'd1);
    for (int i = 0; i < NUM_OPS; i++) begin
      op_sel = NUM_OPS'(1) << i;
      tick();
      chk("t1_load_en_seq", load_en, NUM_OPS'(1) << i);
    end
    op_sel = '0; load_done = 1; tick(); load_done = 0;
    chk("t1_compute", state, 3'd2);
    chk("t1_pstart", phase_start, 1);
    chk("t1_pidx", phase_idx, 0);
    chk("t1_load_en_off", load_en, 0);

    // Three minimum-length iterations, loop condition drops at the third check.
    phase_done = 1; max_iter = 0;
    for (int k = 1; k <= 12; k++) begin
      continue_while = (k < 12);
      tick();
      if (k == 11) chk("t2_not_done_early", state, 3'd3);
    end
    phase_done = 0; continue_while = 0;
    chk("t2_done", state, 3'd4);
    chk("t2_iter", iter_cnt, 3);
    chk("t2_valid", valid, 1);
    chk("t2_err", err, 0);
    start = 1; tick(); start = 0;
    chk("t2_start_in_done_ignored", state, 3'd4);
    ack = 1; tick(); ack = 0;
    chk("t2_ack_idle", state, 3'd0);
    chk("t2_ack_valid", valid, 0);

    // Iteration limit.
    start = 1; tick(); start = 0;
    load_done = 1; tick(); load_done = 0;
    phase_done = 1; continue_while = 1; max_iter = 2;
    for (int i = 0; i < 40 && state != 3'd4; i++) tick();
    clear_inputs();
    chk("t3_done", state, 3'd4);
    chk("t3_iter", iter_cnt, 2);
    chk("t3_err", err, 1);
    chk("t3_valid", valid, 1);
    ack = 1; tick(); ack = 0;

    // Abort in phase 1 after one iteration, then restart clears err/iter_cnt.
    start = 1; tick(); start = 0;
    load_done = 1; tick(); load_done = 0;
    phase_done = 1; continue_while = 1;
    for (int i = 0; i < 5; i++) tick();
    phase_done = 0; tick();
    chk("t4_phase1", phase_idx, 1);
    chk("t4_iter1", iter_cnt, 1);
    abort = 1; tick(); abort = 0;
    chk("t4_abort_idle", state, 3'd0);
    chk("t4_abort_err", err, 1);
    chk("t4_abort_valid", valid, 0);
    start = 1; tick(); start = 0;
    chk("t4_restart_err", err, 0);
    chk("t4_restart_iter", iter_cnt, 0);
    abort = 1; tick(); abort = 0;
    clear_inputs();

    // Asynchronous reset while in CHECK.
    start = 1; tick(); start = 0;
    load_done = 1; tick(); load_done = 0;
    phase_done = 1; continue_while = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_in_check", state, 3'd3);
    async_reset_pulse();
    clear_inputs();
    chk("t5_reset_state", state, 3'd0);
    chk("t5_reset_busy", busy, 0);

`ifdef DIFFEQ_CTRL_TIMEOUT_EN
    // Watchdog expires after TIMEOUT_CYC silent COMPUTE cycles.
    start = 1; tick(); start = 0;
    load_done = 1; tick(); load_done = 0;
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      tick();
      if (i == TIMEOUT_CYC - 1) chk("t6_still_compute", state, 3'd2);
    end
    chk("t6_timeout_done", state, 3'd4);
    chk("t6_timeout_err", err, 1);
    chk("t6_timeout_valid", valid, 1);
    ack = 1; tick(); ack = 0;
    // phase_done on the last budgeted cycle wins.
    start = 1; tick(); start = 0;
    load_done = 1; tick(); load_done = 0;
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      phase_done = (i == TIMEOUT_CYC);
      tick();
    end
    phase_done = 0;
    chk("t7_advance_state", state, 3'd2);
    chk("t7_advance_pidx", phase_idx, 1);
    chk("t7_advance_err", err, 0);
    abort = 1; tick(); abort = 0;
`else
    // Without the watchdog, COMPUTE waits indefinitely.
    start = 1; tick(); start = 0;
    load_done = 1; tick(); load_done = 0;
    for (int i = 0; i < 300; i++) tick();
    chk("t6_waits", state, 3'd2);
    chk("t6_waits_err", err, 0);
    abort = 1; tick(); abort = 0;
`endif
    clear_inputs();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset_pulse();
      end
      start          = ($urandom_range(0, 99) < 30);
      abort          = ($urandom_range(0, 99) < 3);
      op_sel         = ($urandom_range(0, 99) < 40) ? '0 : NUM_OPS'($urandom_range(0, 15));
      load_done      = ($urandom_range(0, 99) < 25);
      phase_done     = ($urandom_range(0, 99) < 50);
      continue_while = ($urandom_range(0, 99) < 80);
      max_iter       = ITER_W'($urandom_range(0, 3));
      ack            = ($urandom_range(0, 99) < 30);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
